// File: rtl/status_branch_unit_pkg.sv
// Shared definitions for the status/branch unit: condition codes, flag
// bit positions within the {Z,V,N} triple, and the handshake FSM encoding.
package status_branch_unit_pkg;

    // Branch condition codes; 101..111 are reserved
    localparam logic [2:0] COND_B   = 3'b000;
    localparam logic [2:0] COND_BEQ = 3'b001;
    localparam logic [2:0] COND_BNE = 3'b010;
    localparam logic [2:0] COND_BLT = 3'b011;
    localparam logic [2:0] COND_BLE = 3'b100;

    // Bit positions inside the status triple {Z,V,N}
    localparam int unsigned FLG_Z = 2;
    localparam int unsigned FLG_V = 1;
    localparam int unsigned FLG_N = 0;

    // Request FSM; the unused code 2'b11 falls back to IDLE
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EVAL = 2'b01,
        ST_RESP = 2'b10
    } sbu_state_t;

endpackage

// File: rtl/status_branch_unit_cond_eval.sv
// Combinational branch-condition evaluator: maps a condition code and the
// {Z,V,N} flags to taken/not-taken, flagging reserved codes.
module branch_cond_eval
    import status_branch_unit_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [2:0] flags,
    output logic       taken,
    output logic       err
);

    logic z;
    logic v;
    logic n;

    assign z = flags[FLG_Z];
    assign v = flags[FLG_V];
    assign n = flags[FLG_N];

    // Decode condition; reserved codes never branch and raise err
    always_comb begin
        taken = 1'b0;
        err   = 1'b0;
        case (cond)
            COND_B:   taken = 1'b1;
            COND_BEQ: taken = z;
            COND_BNE: taken = ~z;
            COND_BLT: taken = n ^ v;
            COND_BLE: taken = (n ^ v) | z;
            default:  err   = 1'b1;
        endcase
    end

endmodule

// File: rtl/status_branch_unit.sv
// Status register plus branch resolution unit. Captures ALU flags, accepts
// branch requests over a req/ack handshake and returns taken/err/next-PC
// two cycles after acceptance.
module status_branch_unit
    import status_branch_unit_pkg::*;
#(
    parameter int PC_W  = 9,
    parameter int IMM_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       alu_z,
    input  logic             loads,
    input  logic             br_req,
    input  logic [2:0]       br_cond,
    input  logic [IMM_W-1:0] br_imm,
    input  logic [PC_W-1:0]  pc,
    output logic             busy,
    output logic             br_ack,
    output logic             br_taken,
    output logic             br_err,
    output logic [PC_W-1:0]  pc_next,
    output logic [2:0]       status
);

    sbu_state_t       state;
    sbu_state_t       state_nxt;
    logic             accept;

    logic [2:0]       cond_lat;
    logic [IMM_W-1:0] imm_lat;
    logic [PC_W-1:0]  pc_lat;

    logic             eval_taken;
    logic             eval_err;
    logic [PC_W-1:0]  imm_ext;
    logic [PC_W-1:0]  pc_seq;
    logic [PC_W-1:0]  pc_tgt;

    // Flag register: independent of the FSM, updated whenever loads is high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            status <= '0;
        end else if (loads) begin
            status <= alu_z;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; requests while busy are ignored
    always_comb begin
        state_nxt = ST_IDLE;
        accept    = 1'b0;
        busy      = 1'b0;
        br_ack    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (br_req) begin
                    accept    = 1'b1;
                    state_nxt = ST_EVAL;
                end
            end
            ST_EVAL: begin
                busy      = 1'b1;
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                busy      = 1'b1;
                br_ack    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Request operands are sampled only on the accepting edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cond_lat <= '0;
            imm_lat  <= '0;
            pc_lat   <= '0;
        end else if (accept) begin
            cond_lat <= br_cond;
            imm_lat  <= br_imm;
            pc_lat   <= pc;
        end
    end

    // Evaluation reads the status register during EVAL, so a load on the
    // accepting edge is seen while a load during EVAL lands too late
    branch_cond_eval u_cond_eval (
        .cond  (cond_lat),
        .flags (status),
        .taken (eval_taken),
        .err   (eval_err)
    );

    if (IMM_W < PC_W) begin : g_imm_sext
        assign imm_ext = {{(PC_W-IMM_W){imm_lat[IMM_W-1]}}, imm_lat};
    end else begin : g_imm_trunc
        assign imm_ext = imm_lat[PC_W-1:0];
    end

    assign pc_seq = pc_lat + PC_W'(1);
    assign pc_tgt = pc_seq + imm_ext;

    // Result registers: written at the end of EVAL, held until the next one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            br_taken <= 1'b0;
            br_err   <= 1'b0;
            pc_next  <= '0;
        end else if (state == ST_EVAL) begin
            br_taken <= eval_taken;
            br_err   <= eval_err;
            pc_next  <= eval_taken ? pc_tgt : pc_seq;
        end
    end

endmodule

// File: tb/tb_status_branch_unit.sv
// Directed self-checking bench for status_branch_unit.
module tb_status_branch_unit;

    logic       clk;
    logic       reset_n;
    logic [2:0] alu_z;
    logic       loads;
    logic       br_req;
    logic [2:0] br_cond;
    logic [7:0] br_imm;
    logic [8:0] pc;
    logic       busy;
    logic       br_ack;
    logic       br_taken;
    logic       br_err;
    logic [8:0] pc_next;
    logic [2:0] status;

    int errors = 0;
    int checks = 0;

    status_branch_unit #(.PC_W(9), .IMM_W(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .alu_z    (alu_z),
        .loads    (loads),
        .br_req   (br_req),
        .br_cond  (br_cond),
        .br_imm   (br_imm),
        .pc       (pc),
        .busy     (busy),
        .br_ack   (br_ack),
        .br_taken (br_taken),
        .br_err   (br_err),
        .pc_next  (pc_next),
        .status   (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Load the status register on one edge
    task automatic load_status(input logic [2:0] v);
        @(negedge clk);
        alu_z = v;
        loads = 1'b1;
        @(negedge clk);
        loads = 1'b0;
    endtask

    // One full request: optional flag load on the accept edge or during EVAL
    task automatic do_branch(input string tag, input logic [2:0] cond, input logic [7:0] imm,
                             input logic [8:0] p, input logic ld_acc, input logic ld_eval,
                             input logic [2:0] z_val, input logic exp_t, input logic exp_e,
                             input logic [8:0] exp_pc);
        @(negedge clk);
        br_req  = 1'b1;
        br_cond = cond;
        br_imm  = imm;
        pc      = p;
        loads   = ld_acc;
        alu_z   = z_val;
        @(negedge clk);
        br_req  = 1'b0;
        loads   = ld_eval;
        alu_z   = z_val;
        check({tag, "_eval_busy"}, busy, 1);
        check({tag, "_eval_ack"}, br_ack, 0);
        @(negedge clk);
        loads = 1'b0;
        check({tag, "_ack"}, br_ack, 1);
        check({tag, "_taken"}, br_taken, exp_t);
        check({tag, "_err"}, br_err, exp_e);
        check({tag, "_pc"}, pc_next, exp_pc);
        @(negedge clk);
        check({tag, "_idle"}, busy, 0);
        check({tag, "_ack_drop"}, br_ack, 0);
        check({tag, "_hold_pc"}, pc_next, exp_pc);
    endtask

    initial begin
        int first_ack;
        int second_ack;
        reset_n = 1'b0;
        alu_z   = '0;
        loads   = 1'b0;
        br_req  = 1'b0;
        br_cond = '0;
        br_imm  = '0;
        pc      = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ack", br_ack, 0);
        check("rst_pc", pc_next, 0);
        check("rst_status", status, 0);
        reset_n = 1'b1;

        // BEQ with Z set
        load_status(3'b100);
        check("status_100", status, 3'b100);
        do_branch("beq", 3'b001, 8'h05, 9'h010, 0, 0, 3'b100, 1, 0, 9'h016);

        // Reset mid-EVAL drops the request and clears everything
        @(negedge clk);
        br_req = 1'b1; br_cond = 3'b000; br_imm = 8'h00; pc = 9'h100;
        @(negedge clk);
        br_req = 1'b0;
        check("rst_mid_busy_pre", busy, 1);
        reset_n = 1'b0;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_taken", br_taken, 0);
        check("rst_mid_err", br_err, 0);
        check("rst_mid_pc", pc_next, 0);
        check("rst_mid_status", status, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mid_noack", br_ack, 0);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_post_noack", br_ack, 0);
            check("rst_post_idle", busy, 0);
        end

        // BLT not taken, then taken with N=1
        load_status(3'b000);
        do_branch("blt_nt", 3'b011, 8'hFE, 9'h020, 0, 0, 3'b000, 0, 0, 9'h021);
        load_status(3'b001);
        do_branch("blt_t", 3'b011, 8'hFE, 9'h020, 0, 0, 3'b001, 1, 0, 9'h01F);

        // BLE: V=1 -> taken; all clear -> not taken
        load_status(3'b010);
        do_branch("ble_t", 3'b100, 8'h03, 9'h030, 0, 0, 3'b010, 1, 0, 9'h034);
        load_status(3'b000);
        do_branch("ble_nt", 3'b100, 8'h03, 9'h030, 0, 0, 3'b000, 0, 0, 9'h031);

        // PC wrap both directions
        do_branch("wrap_up", 3'b000, 8'h01, 9'h1FF, 0, 0, 3'b000, 1, 0, 9'h001);
        do_branch("wrap_dn", 3'b000, 8'h80, 9'h000, 0, 0, 3'b000, 1, 0, 9'h181);

        // Flag timing: load on accept edge is seen; load during EVAL is not
        do_branch("bne_acc", 3'b010, 8'h10, 9'h040, 1, 0, 3'b100, 0, 0, 9'h041);
        check("status_acc", status, 3'b100);
        do_branch("bne_eval", 3'b010, 8'h10, 9'h040, 0, 1, 3'b000, 0, 0, 9'h041);
        check("status_eval", status, 3'b000);

        // Reserved condition
        do_branch("rsvd", 3'b110, 8'h03, 9'h050, 0, 0, 3'b000, 0, 1, 9'h051);

        // Held request: acks exactly three cycles apart
        first_ack  = -1;
        second_ack = -1;
        @(negedge clk);
        br_req = 1'b1; br_cond = 3'b000; br_imm = 8'h02; pc = 9'h060;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (br_ack) begin
                if (first_ack < 0) first_ack = c;
                else if (second_ack < 0) second_ack = c;
            end
        end
        br_req = 1'b0;
        check("b2b_first_seen", (first_ack == 1) ? 1 : 0, 1);
        check("b2b_second_seen", (second_ack >= 0) ? 1 : 0, 1);
        check("b2b_spacing", second_ack - first_ack, 3);
        check("b2b_pc", pc_next, 9'h063);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
